bus_fabric: RTL and testbench



---
 rtl/bus_fabric.sv | 197 +++++++++++++++++++
 tb/tb_bus_fabric.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/bus_fabric.sv
// bus_fabric: CPU + NUM_DSP DSP masters onto DATA_MEM, CPU register windows via AXI-Lite bridge.
// Ports: clk_i/reset_i; cpu_mem_* CPU slave side (ack/err/rdata); dm_* DATA_MEM master side;
// dsp_mem_* packed DSP slave sides; m_axi_* shared AXI-Lite address/data with one-hot per-window handshakes.
module bus_fabric #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int MEM_ADDR_WIDTH = 8,
  parameter logic [ADDR_WIDTH-1:0] DATA_MEM_BASE_ADDR = 32'h0000_0000,
  parameter int NUM_DSP = 2,
  parameter int NUM_PERIPH = 2,
  parameter int PERIPH_REG_ADDR_WIDTH = 5,
  parameter logic [ADDR_WIDTH-1:0] PERIPH_BASE_ADDR = 32'h8000_0000,
  parameter logic [ADDR_WIDTH-1:0] PERIPH_STRIDE = 32'h100,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                              clk_i,
  input  logic                              reset_i,
  input  logic [ADDR_WIDTH-1:0]             cpu_mem_addr_i,
  input  logic [DATA_WIDTH-1:0]             cpu_mem_wdata_i,
  input  logic                              cpu_mem_we_i,
  input  logic                              cpu_mem_re_i,
  output logic [DATA_WIDTH-1:0]             cpu_mem_rdata_o,
  output logic                              cpu_mem_ack_o,
  output logic                              cpu_mem_err_o,
  output logic [MEM_ADDR_WIDTH-1:0]         dm_addr_o,
  output logic [DATA_WIDTH-1:0]             dm_wdata_o,
  output logic                              dm_we_o,
  input  logic [DATA_WIDTH-1:0]             dm_rdata_i,
  input  logic [NUM_DSP*ADDR_WIDTH-1:0]     dsp_mem_addr_i,
  input  logic [NUM_DSP*DATA_WIDTH-1:0]     dsp_mem_wdata_i,
  input  logic [NUM_DSP-1:0]                dsp_mem_req_i,
  input  logic [NUM_DSP-1:0]                dsp_mem_we_i,
  output logic [NUM_DSP*DATA_WIDTH-1:0]     dsp_mem_rdata_o,
  output logic [NUM_DSP-1:0]                dsp_mem_ack_o,
  output logic [PERIPH_REG_ADDR_WIDTH-1:0]  m_axi_awaddr_o,
  output logic [PERIPH_REG_ADDR_WIDTH-1:0]  m_axi_araddr_o,
  output logic [DATA_WIDTH-1:0]             m_axi_wdata_o,
  output logic [DATA_WIDTH/8-1:0]           m_axi_wstrb_o,
  output logic [NUM_PERIPH-1:0]             m_axi_awvalid_o,
  output logic [NUM_PERIPH-1:0]             m_axi_wvalid_o,
  output logic [NUM_PERIPH-1:0]             m_axi_bready_o,
  output logic [NUM_PERIPH-1:0]             m_axi_arvalid_o,
  output logic [NUM_PERIPH-1:0]             m_axi_rready_o,
  input  logic [NUM_PERIPH-1:0]             m_axi_awready_i,
  input  logic [NUM_PERIPH-1:0]             m_axi_wready_i,
  input  logic [NUM_PERIPH-1:0]             m_axi_bvalid_i,
  input  logic [NUM_PERIPH-1:0]             m_axi_arready_i,
  input  logic [NUM_PERIPH-1:0]             m_axi_rvalid_i,
  input  logic [2*NUM_PERIPH-1:0]           m_axi_bresp_i,
  input  logic [2*NUM_PERIPH-1:0]           m_axi_rresp_i,
  input  logic [NUM_PERIPH*DATA_WIDTH-1:0]  m_axi_rdata_i
);
  localparam int RW = NUM_DSP > 1 ? $clog2(NUM_DSP) : 1;
  localparam int PW = NUM_PERIPH > 1 ? $clog2(NUM_PERIPH) : 1;
  localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [ADDR_WIDTH-1:0] ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH-1:0] DM_SIZE = ONE << (MEM_ADDR_WIDTH + 2);
  localparam logic [ADDR_WIDTH-1:0] WIN_SIZE = ONE << PERIPH_REG_ADDR_WIDTH;
  typedef enum logic [2:0] {IDLE, WADDR, WRESP, RADDR, RDATA, DONE} state_t;
  function automatic logic dm_hit(input logic [ADDR_WIDTH-1:0] a);
    return a - DATA_MEM_BASE_ADDR < DM_SIZE;
  endfunction
  state_t state;
  logic [RW-1:0] rr_ptr, g_idx;
  logic [PW-1:0] p_idx, k_q;
  logic [CW-1:0] cnt;
  logic [NUM_DSP-1:0] dsp_hit;
  logic [NUM_PERIPH-1:0] p_oh, k_oh;
  logic [DATA_WIDTH-1:0] rd_q;
  logic [PERIPH_REG_ADDR_WIDTH-1:0] addr_q;
  logic err_q, g_any, p_hit, cpu_act, cpu_dm, cpu_p, cpu_unm, idle, busy;
  assign idle = state == IDLE;
  assign busy = state inside {WADDR, WRESP, RADDR, RDATA};
  assign cpu_act = cpu_mem_we_i | cpu_mem_re_i;
  assign cpu_dm = idle & cpu_act & dm_hit(cpu_mem_addr_i);
  assign cpu_p = idle & cpu_act & !dm_hit(cpu_mem_addr_i) & p_hit;
  assign cpu_unm = idle & cpu_act & !dm_hit(cpu_mem_addr_i) & !p_hit;
  assign p_oh = NUM_PERIPH'(1) << p_idx;
  assign k_oh = NUM_PERIPH'(1) << k_q;
  assign m_axi_awaddr_o = addr_q;
  assign m_axi_araddr_o = addr_q;
  always_comb begin
    p_hit = 1'b0;
    p_idx = '0;
    for (int k = NUM_PERIPH - 1; k >= 0; k--)
      if (cpu_mem_addr_i - PERIPH_BASE_ADDR - ADDR_WIDTH'(k) * PERIPH_STRIDE < WIN_SIZE) begin
        p_hit = 1'b1;
        p_idx = PW'(k);
      end
    for (int j = 0; j < NUM_DSP; j++)
      dsp_hit[j] = dsp_mem_req_i[j] & dm_hit(dsp_mem_addr_i[j*ADDR_WIDTH +: ADDR_WIDTH]);
    // scanning downward leaves the first requester at or after rr_ptr
    g_any = 1'b0;
    g_idx = '0;
    for (int j = NUM_DSP - 1; j >= 0; j--)
      if (dsp_hit[(int'(rr_ptr) + j) % NUM_DSP]) begin
        g_any = 1'b1;
        g_idx = RW'((int'(rr_ptr) + j) % NUM_DSP);
      end
  end
  always_comb begin
    dm_addr_o = '0;
    dm_wdata_o = '0;
    dm_we_o = 1'b0;
    dsp_mem_rdata_o = '0;
    dsp_mem_ack_o = dsp_mem_req_i & ~dsp_hit;
    if (cpu_dm) begin
      dm_addr_o = cpu_mem_addr_i[MEM_ADDR_WIDTH+1:2];
      dm_wdata_o = cpu_mem_wdata_i;
      dm_we_o = cpu_mem_we_i;
    end else if (g_any) begin
      dm_addr_o = dsp_mem_addr_i[int'(g_idx)*ADDR_WIDTH+2 +: MEM_ADDR_WIDTH];
      dm_wdata_o = dsp_mem_wdata_i[int'(g_idx)*DATA_WIDTH +: DATA_WIDTH];
      dm_we_o = dsp_mem_we_i[g_idx];
      dsp_mem_ack_o[g_idx] = 1'b1;
      dsp_mem_rdata_o[int'(g_idx)*DATA_WIDTH +: DATA_WIDTH] = dsp_mem_we_i[g_idx] ? '0 : dm_rdata_i;
    end
    cpu_mem_ack_o = cpu_dm | cpu_unm | (state == DONE);
    cpu_mem_err_o = cpu_unm | ((state == DONE) & err_q);
    cpu_mem_rdata_o = state == DONE ? rd_q : (cpu_dm & !cpu_mem_we_i) ? dm_rdata_i : '0;
  end
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state <= IDLE;
      rr_ptr <= '0;
      cnt <= '0;
      k_q <= '0;
      addr_q <= '0;
      rd_q <= '0;
      err_q <= 1'b0;
      m_axi_wdata_o <= '0;
      m_axi_wstrb_o <= '0;
      m_axi_awvalid_o <= '0;
      m_axi_wvalid_o <= '0;
      m_axi_bready_o <= '0;
      m_axi_arvalid_o <= '0;
      m_axi_rready_o <= '0;
    end else begin
      if (!cpu_dm && g_any) rr_ptr <= RW'((int'(g_idx) + 1) % NUM_DSP);
      cnt <= busy ? cnt + 1'b1 : '0;
      if (busy && cnt == CW'(TIMEOUT_CYCLES - 1)) begin
        state <= DONE;
        err_q <= 1'b1;
        rd_q <= '0;
        m_axi_awvalid_o <= '0;
        m_axi_wvalid_o <= '0;
        m_axi_bready_o <= '0;
        m_axi_arvalid_o <= '0;
        m_axi_rready_o <= '0;
      end else begin
        case (state)
          IDLE: if (cpu_p) begin
            k_q <= p_idx;
            addr_q <= cpu_mem_addr_i[PERIPH_REG_ADDR_WIDTH-1:0];
            m_axi_wdata_o <= cpu_mem_wdata_i;
            m_axi_wstrb_o <= '1;
            err_q <= 1'b0;
            rd_q <= '0;
            if (cpu_mem_we_i) begin
              m_axi_awvalid_o <= p_oh;
              m_axi_wvalid_o <= p_oh;
              state <= WADDR;
            end else begin
              m_axi_arvalid_o <= p_oh;
              state <= RADDR;
            end
          end
          WADDR: begin
            if (m_axi_awready_i[k_q]) m_axi_awvalid_o <= '0;
            if (m_axi_wready_i[k_q]) m_axi_wvalid_o <= '0;
            if ((!m_axi_awvalid_o[k_q] || m_axi_awready_i[k_q]) && (!m_axi_wvalid_o[k_q] || m_axi_wready_i[k_q])) begin
              m_axi_bready_o <= k_oh;
              state <= WRESP;
            end
          end
          WRESP: if (m_axi_bvalid_i[k_q]) begin
            m_axi_bready_o <= '0;
            err_q <= |m_axi_bresp_i[2*int'(k_q) +: 2];
            state <= DONE;
          end
          RADDR: if (m_axi_arready_i[k_q]) begin
            m_axi_arvalid_o <= '0;
            m_axi_rready_o <= k_oh;
            state <= RDATA;
          end
          RDATA: if (m_axi_rvalid_i[k_q]) begin
            m_axi_rready_o <= '0;
            rd_q <= m_axi_rdata_i[int'(k_q)*DATA_WIDTH +: DATA_WIDTH];
            err_q <= |m_axi_rresp_i[2*int'(k_q) +: 2];
            state <= DONE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_bus_fabric.sv
// tb_bus_fabric: directed self-checking bench for bus_fabric.
module tb_bus_fabric;
  logic clk = 1'b0, reset_i;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic cpu_we, cpu_re, cpu_ack, cpu_err;
  logic [7:0] dm_addr;
  logic [31:0] dm_wdata, dm_rdata;
  logic dm_we;
  logic [63:0] dsp_addr, dsp_wdata, dsp_rdata;
  logic [1:0] dsp_req, dsp_we, dsp_ack;
  logic [4:0] awaddr, araddr;
  logic [31:0] wdata;
  logic [3:0] wstrb;
  logic [1:0] awvalid, wvalid, bready, arvalid, rready;
  logic [1:0] awready, wready, bvalid, arready, rvalid;
  logic [3:0] bresp, rresp;
  logic [63:0] rdata;
  int pass = 0, total = 0;
  bus_fabric #(.TIMEOUT_CYCLES(8)) dut (
    .clk_i(clk), .reset_i(reset_i),
    .cpu_mem_addr_i(cpu_addr), .cpu_mem_wdata_i(cpu_wdata), .cpu_mem_we_i(cpu_we), .cpu_mem_re_i(cpu_re),
    .cpu_mem_rdata_o(cpu_rdata), .cpu_mem_ack_o(cpu_ack), .cpu_mem_err_o(cpu_err),
    .dm_addr_o(dm_addr), .dm_wdata_o(dm_wdata), .dm_we_o(dm_we), .dm_rdata_i(dm_rdata),
    .dsp_mem_addr_i(dsp_addr), .dsp_mem_wdata_i(dsp_wdata), .dsp_mem_req_i(dsp_req), .dsp_mem_we_i(dsp_we),
    .dsp_mem_rdata_o(dsp_rdata), .dsp_mem_ack_o(dsp_ack),
    .m_axi_awaddr_o(awaddr), .m_axi_araddr_o(araddr), .m_axi_wdata_o(wdata), .m_axi_wstrb_o(wstrb),
    .m_axi_awvalid_o(awvalid), .m_axi_wvalid_o(wvalid), .m_axi_bready_o(bready),
    .m_axi_arvalid_o(arvalid), .m_axi_rready_o(rready),
    .m_axi_awready_i(awready), .m_axi_wready_i(wready), .m_axi_bvalid_i(bvalid),
    .m_axi_arready_i(arready), .m_axi_rvalid_i(rvalid),
    .m_axi_bresp_i(bresp), .m_axi_rresp_i(rresp), .m_axi_rdata_i(rdata)
  );
  always #5 clk = ~clk;
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic mid();
    @(negedge clk);
  endtask
  task automatic test_reset();
    reset_i = 1'b1;
    cyc();
    cyc();
    mid();
    total++; if (cpu_ack !== 1'b0) $display("FAIL reset_ack got %b exp 0", cpu_ack); else pass++;
    total++; if (cpu_err !== 1'b0) $display("FAIL reset_err got %b exp 0", cpu_err); else pass++;
    total++; if ({awvalid, wvalid, bready, arvalid, rready} !== 10'b0) $display("FAIL reset_axi got %b exp 0", {awvalid, wvalid, bready, arvalid, rready}); else pass++;
    total++; if (wstrb !== 4'h0) $display("FAIL reset_wstrb got %h exp 0", wstrb); else pass++;
    total++; if ({dsp_ack, dm_we} !== 3'b0) $display("FAIL reset_dm got %b exp 0", {dsp_ack, dm_we}); else pass++;
    cyc();
    reset_i = 1'b0;
  endtask
  task automatic test_round_robin();
    dsp_addr = {32'h34, 32'h20};
    dm_rdata = 32'h55;
    dsp_req = 2'b11;
    for (int i = 0; i < 4; i++) begin
      mid();
      total++; if (dsp_ack !== (i % 2 == 0 ? 2'b01 : 2'b10)) $display("FAIL rr_gnt%0d got %b exp %b", i, dsp_ack, i % 2 == 0 ? 2'b01 : 2'b10); else pass++;
      total++; if (dm_addr !== (i % 2 == 0 ? 8'd8 : 8'd13)) $display("FAIL rr_addr%0d got %0d exp %0d", i, dm_addr, i % 2 == 0 ? 8 : 13); else pass++;
      total++; if (dsp_rdata !== (i % 2 == 0 ? 64'h55 : 64'h55_0000_0000)) $display("FAIL rr_rdata%0d got %h", i, dsp_rdata); else pass++;
      cyc();
    end
    dsp_req = 2'b00;
  endtask
  task automatic test_cpu_priority();
    cpu_re = 1'b1;
    cpu_addr = 32'h10;
    dsp_req = 2'b11;
    dm_rdata = 32'hCAFE;
    mid();
    total++; if (dm_addr !== 8'd4) $display("FAIL prio_addr got %0d exp 4", dm_addr); else pass++;
    total++; if ({cpu_ack, cpu_err} !== 2'b10) $display("FAIL prio_ack got %b exp 10", {cpu_ack, cpu_err}); else pass++;
    total++; if (cpu_rdata !== 32'hCAFE) $display("FAIL prio_rdata got %h exp cafe", cpu_rdata); else pass++;
    total++; if (dsp_ack !== 2'b00 || dsp_rdata !== 64'h0) $display("FAIL prio_dsp got %b/%h exp 00/0", dsp_ack, dsp_rdata); else pass++;
    cyc();
    cpu_re = 1'b0;
    mid();
    total++; if (dsp_ack !== 2'b01 || dm_addr !== 8'd8) $display("FAIL prio_rr got %b/%0d exp 01/8", dsp_ack, dm_addr); else pass++;
    cyc();
    dsp_req = 2'b10;
    dsp_we = 2'b10;
    dsp_wdata = {32'h77, 32'h0};
    mid();
    total++; if ({dm_we, dsp_ack} !== 3'b110 || dm_wdata !== 32'h77) $display("FAIL dsp_write got %b/%h exp 110/77", {dm_we, dsp_ack}, dm_wdata); else pass++;
    total++; if (dsp_rdata !== 64'h0) $display("FAIL dsp_write_rdata got %h exp 0", dsp_rdata); else pass++;
    cyc();
    dsp_req = 2'b00;
    dsp_we = 2'b00;
  endtask
  task automatic test_unmapped();
    cpu_re = 1'b1;
    cpu_addr = 32'h4000_0000;
    dsp_addr = {32'h34, 32'h4000_0000};
    dsp_req = 2'b01;
    dsp_we = 2'b01;
    mid();
    total++; if ({cpu_ack, cpu_err} !== 2'b11) $display("FAIL unm_cpu got %b exp 11", {cpu_ack, cpu_err}); else pass++;
    total++; if (cpu_rdata !== 32'h0) $display("FAIL unm_rdata got %h exp 0", cpu_rdata); else pass++;
    total++; if (dsp_ack !== 2'b01 || dm_we !== 1'b0 || dsp_rdata !== 64'h0) $display("FAIL unm_dsp got %b/%b/%h exp 01/0/0", dsp_ack, dm_we, dsp_rdata); else pass++;
    cyc();
    cpu_re = 1'b0;
    dsp_req = 2'b00;
    dsp_we = 2'b00;
    mid();
    total++; if ({arvalid, awvalid, cpu_ack} !== 5'b0) $display("FAIL unm_idle got %b exp 0", {arvalid, awvalid, cpu_ack}); else pass++;
    cyc();
  endtask
  task automatic test_periph_write();
    cpu_we = 1'b1;
    cpu_addr = 32'h8000_0104;
    cpu_wdata = 32'hDEADBEEF;
    mid();
    total++; if (cpu_ack !== 1'b0) $display("FAIL pw_c0_ack got %b exp 0", cpu_ack); else pass++;
    cyc();
    awready = 2'b00;
    wready = 2'b10;
    mid();
    total++; if (awvalid !== 2'b10 || wvalid !== 2'b10) $display("FAIL pw_c1_valid got %b/%b exp 10/10", awvalid, wvalid); else pass++;
    total++; if (awaddr !== 5'd4 || wdata !== 32'hDEADBEEF || wstrb !== 4'hF) $display("FAIL pw_c1_bus got %h/%h/%h exp 4/deadbeef/f", awaddr, wdata, wstrb); else pass++;
    cyc();
    awready = 2'b10;
    wready = 2'b00;
    mid();
    total++; if (awvalid !== 2'b10 || wvalid !== 2'b00 || cpu_ack !== 1'b0) $display("FAIL pw_c2 got %b/%b/%b exp 10/00/0", awvalid, wvalid, cpu_ack); else pass++;
    cyc();
    awready = 2'b00;
    bvalid = 2'b10;
    bresp = 4'b0000;
    mid();
    total++; if (bready !== 2'b10 || awvalid !== 2'b00 || cpu_ack !== 1'b0) $display("FAIL pw_c3 got %b/%b/%b exp 10/00/0", bready, awvalid, cpu_ack); else pass++;
    cyc();
    bvalid = 2'b00;
    mid();
    total++; if ({cpu_ack, cpu_err} !== 2'b10 || bready !== 2'b00) $display("FAIL pw_c4 got %b/%b exp 10/00", {cpu_ack, cpu_err}, bready); else pass++;
    cyc();
    cpu_we = 1'b0;
    mid();
    total++; if (cpu_ack !== 1'b0) $display("FAIL pw_c5_ack got %b exp 0", cpu_ack); else pass++;
    cyc();
  endtask
  task automatic test_periph_read();
    cpu_re = 1'b1;
    cpu_addr = 32'h8000_0008;
    mid();
    total++; if (cpu_ack !== 1'b0) $display("FAIL pr_c0_ack got %b exp 0", cpu_ack); else pass++;
    cyc();
    arready = 2'b01;
    dsp_addr = {32'h34, 32'h20};
    dsp_req = 2'b01;
    mid();
    total++; if (arvalid !== 2'b01 || araddr !== 5'd8) $display("FAIL pr_c1 got %b/%h exp 01/8", arvalid, araddr); else pass++;
    total++; if (dsp_ack !== 2'b01 || dm_addr !== 8'd8) $display("FAIL pr_dsp_owns got %b/%0d exp 01/8", dsp_ack, dm_addr); else pass++;
    cyc();
    arready = 2'b00;
    dsp_req = 2'b00;
    rvalid = 2'b01;
    rdata = 64'h1234;
    rresp = 4'b0010;
    mid();
    total++; if (rready !== 2'b01 || arvalid !== 2'b00 || cpu_ack !== 1'b0) $display("FAIL pr_c2 got %b/%b/%b exp 01/00/0", rready, arvalid, cpu_ack); else pass++;
    cyc();
    rvalid = 2'b00;
    rdata = 64'h0;
    rresp = 4'b0000;
    mid();
    total++; if ({cpu_ack, cpu_err} !== 2'b11 || cpu_rdata !== 32'h1234) $display("FAIL pr_c3 got %b/%h exp 11/1234", {cpu_ack, cpu_err}, cpu_rdata); else pass++;
    cyc();
    cpu_re = 1'b0;
    mid();
    total++; if (cpu_ack !== 1'b0 || rready !== 2'b00) $display("FAIL pr_c4 got %b/%b exp 0/00", cpu_ack, rready); else pass++;
    cyc();
  endtask
  task automatic test_timeout();
    cpu_re = 1'b1;
    cpu_addr = 32'h8000_0000;
    cyc();
    for (int t = 1; t <= 8; t++) begin
      mid();
      total++; if (arvalid !== 2'b01 || cpu_ack !== 1'b0) $display("FAIL to_wait%0d got %b/%b exp 01/0", t, arvalid, cpu_ack); else pass++;
      cyc();
    end
    mid();
    total++; if ({cpu_ack, cpu_err} !== 2'b11 || cpu_rdata !== 32'h0) $display("FAIL to_done got %b/%h exp 11/0", {cpu_ack, cpu_err}, cpu_rdata); else pass++;
    total++; if (arvalid !== 2'b00) $display("FAIL to_arvalid got %b exp 00", arvalid); else pass++;
    cyc();
    cpu_re = 1'b0;
    mid();
    total++; if (arvalid !== 2'b00 || cpu_ack !== 1'b0) $display("FAIL to_after got %b/%b exp 00/0", arvalid, cpu_ack); else pass++;
    cyc();
  endtask
  task automatic test_reset_mid();
    cpu_we = 1'b1;
    cpu_addr = 32'h8000_0000;
    cpu_wdata = 32'h1;
    cyc();
    awready = 2'b01;
    wready = 2'b01;
    mid();
    total++; if (awvalid !== 2'b01 || wvalid !== 2'b01) $display("FAIL rm_c1 got %b/%b exp 01/01", awvalid, wvalid); else pass++;
    cyc();
    awready = 2'b00;
    wready = 2'b00;
    mid();
    total++; if (bready !== 2'b01) $display("FAIL rm_wresp got %b exp 01", bready); else pass++;
    reset_i = 1'b1;
    cyc();
    reset_i = 1'b0;
    cpu_we = 1'b0;
    mid();
    total++; if (bready !== 2'b00 || cpu_ack !== 1'b0) $display("FAIL rm_c3 got %b/%b exp 00/0", bready, cpu_ack); else pass++;
    cyc();
    mid();
    total++; if ({cpu_ack, awvalid, wvalid, bready} !== 7'b0) $display("FAIL rm_c4 got %b exp 0", {cpu_ack, awvalid, wvalid, bready}); else pass++;
    cyc();
  endtask
  initial begin
    reset_i = 1'b1;
    {cpu_addr, cpu_wdata, cpu_we, cpu_re, dm_rdata} = '0;
    {dsp_addr, dsp_wdata, dsp_req, dsp_we} = '0;
    {awready, wready, bvalid, arready, rvalid, bresp, rresp, rdata} = '0;
    test_reset();
    test_round_robin();
    test_cpu_priority();
    test_unmapped();
    test_periph_write();
    test_periph_read();
    test_timeout();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
